// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - round-robin two-port arbiter and access sequencer for the external 1Mx16 SRAM
module sram_arbiter #(
    parameter int ADDR_W        = 20,
    parameter int DATA_W        = 16,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [1:0]        a_be,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ready,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [1:0]        b_be,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ready,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_in,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_ub_n,
    output logic              sram_lb_n
);

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

    state_t            state;
    state_t            state_next;
    logic              last_b;      // 1 = port B won the previous arbitration
    logic              owner_b;     // port owning the access in flight
    logic [3:0]        cnt;
    logic [1:0]        be_r;
    logic              grant;
    logic              pick_b;
    logic              we_sel;
    logic [1:0]        be_sel;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] wdata_sel;
    logic [1:0]        be_nxt;

    always_comb begin
        state_next = state;
        grant      = 1'b0;
        // B wins when it is alone, or on a tie when A was granted last.
        pick_b     = b_req && (!a_req || !last_b);
        we_sel     = pick_b ? b_we    : a_we;
        be_sel     = pick_b ? b_be    : a_be;
        addr_sel   = pick_b ? b_addr  : a_addr;
        wdata_sel  = pick_b ? b_wdata : a_wdata;
        case (state)
            IDLE: begin
                if (a_req || b_req) begin
                    grant      = 1'b1;
                    state_next = we_sel ? WR : RD;
                end
            end
            default: begin
                if (cnt == 4'd0) begin
                    state_next = IDLE;
                end
            end
        endcase
        be_nxt = grant ? be_sel : be_r;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Strobes are registered from the next state so they line up with the
    // RD/WR cycles themselves; IDLE always drives the bus-turnaround values.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_b      <= 1'b1;
            owner_b     <= 1'b0;
            cnt         <= 4'd0;
            be_r        <= 2'b00;
            a_ready     <= 1'b0;
            b_ready     <= 1'b0;
            a_rvalid    <= 1'b0;
            b_rvalid    <= 1'b0;
            a_rdata     <= '0;
            b_rdata     <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_ce_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            sram_we_n   <= 1'b1;
            sram_ub_n   <= 1'b1;
            sram_lb_n   <= 1'b1;
        end else begin
            a_ready  <= 1'b0;
            b_ready  <= 1'b0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            if (grant) begin
                last_b      <= pick_b;
                owner_b     <= pick_b;
                be_r        <= be_sel;
                cnt         <= CNT_LOAD;
                sram_addr   <= addr_sel;
                sram_dq_out <= wdata_sel;
                a_ready     <= !pick_b;
                b_ready     <= pick_b;
            end else if (state != IDLE && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            // Capture pad data on the edge that ends the last read cycle.
            if (state == RD && cnt == 4'd0) begin
                if (owner_b) begin
                    b_rdata  <= sram_dq_in;
                    b_rvalid <= 1'b1;
                end else begin
                    a_rdata  <= sram_dq_in;
                    a_rvalid <= 1'b1;
                end
            end
            sram_ce_n  <= (state_next == IDLE);
            sram_oe_n  <= (state_next != RD);
            sram_we_n  <= (state_next != WR);
            sram_ub_n  <= (state_next == IDLE) || (state_next == WR && !be_nxt[1]);
            sram_lb_n  <= (state_next == IDLE) || (state_next == WR && !be_nxt[0]);
            sram_dq_oe <= (state_next == WR);
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed self-checking bench for sram_arbiter
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_req, a_we, b_req, b_we;
    logic [1:0]  a_be, b_be;
    logic [19:0] a_addr, b_addr;
    logic [15:0] a_wdata, b_wdata;
    logic        a_ready, a_rvalid, b_ready, b_rvalid;
    logic [15:0] a_rdata, b_rdata;
    logic [19:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    // second instance, ACCESS_CYCLES = 1, port B only
    logic        u1_zero = 1'b0;
    logic [1:0]  u1_zero2 = 2'b00;
    logic [19:0] u1_zaddr = 20'h0;
    logic [15:0] u1_zdata = 16'h0;
    logic [15:0] u1_dq_in = 16'h0A0A;
    logic        u1_b_req;
    logic        u1_a_ready, u1_a_rvalid, u1_b_ready, u1_b_rvalid;
    logic [15:0] u1_a_rdata, u1_b_rdata, u1_dq_out;
    logic [19:0] u1_addr;
    logic        u1_dq_oe, u1_ce_n, u1_oe_n, u1_we_n, u1_ub_n, u1_lb_n;

    logic [15:0] mem [0:255];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sram_arbiter #(.ADDR_W(20), .DATA_W(16), .ACCESS_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ready(a_ready), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ready(b_ready), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
    );

    sram_arbiter #(.ADDR_W(20), .DATA_W(16), .ACCESS_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst),
        .a_req(u1_zero), .a_we(u1_zero), .a_be(u1_zero2), .a_addr(u1_zaddr), .a_wdata(u1_zdata),
        .a_ready(u1_a_ready), .a_rvalid(u1_a_rvalid), .a_rdata(u1_a_rdata),
        .b_req(u1_b_req), .b_we(u1_zero), .b_be(u1_zero2), .b_addr(u1_zaddr), .b_wdata(u1_zdata),
        .b_ready(u1_b_ready), .b_rvalid(u1_b_rvalid), .b_rdata(u1_b_rdata),
        .sram_addr(u1_addr), .sram_dq_out(u1_dq_out), .sram_dq_oe(u1_dq_oe),
        .sram_dq_in(u1_dq_in), .sram_ce_n(u1_ce_n), .sram_oe_n(u1_oe_n),
        .sram_we_n(u1_we_n), .sram_ub_n(u1_ub_n), .sram_lb_n(u1_lb_n)
    );

    // SRAM model: byte-lane writes on the clock, asynchronous reads.
    always @(posedge clk) begin
        if (rst) begin
            mem[8'h30] <= 16'h5566;
        end else if (!sram_ce_n && !sram_we_n) begin
            if (!sram_ub_n) mem[sram_addr[7:0]][15:8] <= sram_dq_out[15:8];
            if (!sram_lb_n) mem[sram_addr[7:0]][7:0]  <= sram_dq_out[7:0];
        end
    end

    assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[7:0]] : 16'h0000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    int order[$];
    int grants, viol, ka, kb;
    logic prev_ce_n;

    initial begin
        rst = 1'b1; a_req = 0; b_req = 0; u1_b_req = 0;
        a_we = 0; b_we = 0; a_be = 2'b11; b_be = 2'b11;
        a_addr = 0; b_addr = 0; a_wdata = 0; b_wdata = 0;
        repeat (3) step();
        check("rst_ce_n", sram_ce_n, 1);
        check("rst_strobes", {sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 4'hF);
        check("rst_dq_oe", sram_dq_oe, 0);
        check("rst_addr", sram_addr, 0);
        check("rst_dq_out", sram_dq_out, 0);
        check("rst_ready", {a_ready, b_ready, a_rvalid, b_rvalid}, 0);
        check("rst_rdata", {a_rdata, b_rdata}, 0);
        rst = 1'b0;
        step();

        // A write 0xBEEF @0x10, be=11
        a_req = 1; a_we = 1; a_be = 2'b11; a_addr = 20'h00010; a_wdata = 16'hBEEF;
        step();
        check("wr_a_ready", a_ready, 1);
        check("wr_c1_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 4'b0101);
        check("wr_addr", sram_addr, 20'h00010);
        check("wr_dq_out", sram_dq_out, 16'hBEEF);
        a_req = 0;
        step();
        check("wr_c2_ready", a_ready, 0);
        check("wr_c2_strobes", {sram_we_n, sram_dq_oe}, 2'b01);
        step();
        check("wr_idle_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 4'b1110);
        check("wr_mem", mem[8'h10], 16'hBEEF);

        // A read @0x10
        a_req = 1; a_we = 0;
        step();
        check("rd_a_ready", a_ready, 1);
        check("rd_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 4'b0010);
        a_req = 0;
        step();
        check("rd_c2_rvalid", a_rvalid, 0);
        step();
        check("rd_a_rvalid", a_rvalid, 1);
        check("rd_a_rdata", a_rdata, 16'hBEEF);
        check("rd_b_rvalid", b_rvalid, 0);
        step();
        check("rd_rvalid_pulse", a_rvalid, 0);

        // B write be=10 of 0x12AB over 0x5566, then read back
        b_req = 1; b_we = 1; b_be = 2'b10; b_addr = 20'h00030; b_wdata = 16'h12AB;
        step();
        check("be_b_ready", b_ready, 1);
        check("be_lanes", {sram_we_n, sram_ub_n, sram_lb_n}, 3'b001);
        b_req = 0;
        step();
        check("be_lanes_c2", {sram_ub_n, sram_lb_n}, 2'b01);
        step();
        check("be_mem", mem[8'h30], 16'h1266);
        b_req = 1; b_we = 0;
        step();
        b_req = 0;
        step();
        step();
        check("be_b_rvalid", b_rvalid, 1);
        check("be_b_rdata", b_rdata, 16'h1266);
        step();

        // Both ports requesting continuously; last grant was B so A goes first.
        ka = 0; kb = 0; grants = 0; viol = 0; prev_ce_n = 1'b1;
        a_req = 1; a_we = 0; a_be = 2'b11; a_addr = 20'h40; a_wdata = 16'hA000;
        b_req = 1; b_we = 1; b_be = 2'b11; b_addr = 20'h41; b_wdata = 16'hB000;
        for (int cyc = 0; cyc < 200 && grants < 20; cyc++) begin
            step();
            if ((a_ready || b_ready) && !prev_ce_n) viol++;
            if (sram_ce_n && sram_dq_oe) viol++;
            if (a_ready) begin
                order.push_back(0); grants++; ka++;
                a_we = ka[0]; a_addr = 20'h40 + 20'(2 * ka); a_wdata = 16'hA000 + 16'(ka);
            end
            if (b_ready) begin
                order.push_back(1); grants++; kb++;
                b_we = ~kb[0]; b_addr = 20'h41 + 20'(2 * kb); b_wdata = 16'hB000 + 16'(kb);
            end
            prev_ce_n = sram_ce_n;
        end
        a_req = 0; b_req = 0;
        check("rr_grants", grants, 20);
        check("rr_violations", viol, 0);
        foreach (order[i]) check($sformatf("rr_order_%0d", i), order[i], i % 2);
        repeat (4) step();

        // Reset in the 2nd cycle of a read aborts it
        a_req = 1; a_we = 0; a_addr = 20'h00010;
        step();
        check("abort_ready", a_ready, 1);
        a_req = 0;
        step();
        rst = 1;
        step();
        check("abort_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 5'h1F);
        check("abort_rvalid", a_rvalid, 0);
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("abort_no_rvalid", a_rvalid | b_rvalid, 0);
        end
        a_req = 1;
        step();
        check("post_ready", a_ready, 1);
        a_req = 0;
        step();
        step();
        check("post_rvalid", a_rvalid, 1);
        check("post_rdata", a_rdata, 16'hBEEF);

        // ACCESS_CYCLES = 1: back-to-back B reads every 2 cycles
        u1_b_req = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("ac1_ready_%0d", i), u1_b_ready, (i % 2) == 0);
            if (i % 2 == 1) check("ac1_rdata", {u1_b_rvalid, u1_b_rdata}, {1'b1, 16'h0A0A});
        end
        u1_b_req = 0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares the single-ported 1M×16 external SRAM between two requesters using fair round-robin arbitration. Port A is the detection-map writer fed by the green/red classifiers on the VGA pixel clock. Port B is the host/readout side, which replaces the switch-driven test path. The block sequences every SRAM access itself, including chip/output/write enables and byte lanes, and inserts a bus-idle cycle between accesses. The top-level tri-state buffer on SRAM_DATA is driven from `sram_dq_out`/`sram_dq_oe`.

## Interface
- `ADDR_W`, 20, SRAM word-address width
- `DATA_W`, 16, SRAM data width
- `ACCESS_CYCLES`, 2, cycles a read or write holds the SRAM bus; legal range 1..15

- `clk`  in  1  single clock (VGA_CLK domain); all logic on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `a_req`, `b_req`  in  1  access request; held until the matching `_ready` pulse
- `a_we`, `b_we`  in  1  1 = write, 0 = read
- `a_be`, `b_be`  in  2  byte enables for writes; [1] upper, [0] lower
- `a_addr`, `b_addr`  in  ADDR_W  word address
- `a_wdata`, `b_wdata`  in  DATA_W  write data
- `a_ready`, `b_ready`  out  1  one-cycle accept pulse
- `a_rvalid`, `b_rvalid`  out  1  one-cycle read-data-valid pulse
- `a_rdata`, `b_rdata`  out  DATA_W  read data; held until that port's next read completes
- `sram_addr`  out  ADDR_W  SRAM address
- `sram_dq_out`  out  DATA_W  data to the pad tri-state
- `sram_dq_oe`  out  1  pad output enable; 1 only during writes
- `sram_dq_in`  in  DATA_W  data from the pads
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`, `sram_ub_n`, `sram_lb_n`  out  1  active-low SRAM strobes

## Operation
- FSM states are IDLE, RD and WR.
- Arbitration happens only at an edge where the state is IDLE and at least one `_req` is high:
  - If only one port requests, that port wins.
  - If both request, the port not granted last time wins.
  - The `last` pointer updates to the winner.
- On a win, the winner's we/be/addr/wdata are latched into internal registers. The FSM enters WR if `we` = 1, otherwise RD. The cycle counter loads ACCESS_CYCLES−1.
- In RD or WR, the counter decrements every cycle. When it reaches 0, the next state is IDLE. There is no RD/WR → RD/WR transition, so IDLE always separates accesses.
- Strobes in RD: `ce_n` = 0, `oe_n` = 0, `we_n` = 1, `ub_n` = `lb_n` = 0, `dq_oe` = 0.
- Strobes in WR: `ce_n` = 0, `oe_n` = 1, `we_n` = 0, `ub_n` = ~be[1], `lb_n` = ~be[0], `dq_oe` = 1, `dq_out` = latched wdata.
  - A write with be = 2'b00 still occupies the bus for ACCESS_CYCLES cycles but modifies nothing.
- Strobes in IDLE: all `_n` outputs = 1 and `dq_oe` = 0. This is the bus turnaround cycle.
- `sram_addr` holds the latched address in RD/WR and keeps its last value in IDLE.
- On the edge ending the final RD cycle, `sram_dq_in` is registered into the owner's `_rdata`.
- A port's requests complete in issue order, since the arbiter handles one access at a time.
- Every output is registered. In particular, no combinational path exists from `_req` to `_ready`.

## Timing
- Reset values:
  - State = IDLE.
  - `last` = B, so A wins the first tie.
  - All `sram_*_n` = 1, `sram_dq_oe` = 0, `sram_addr` = 0, `sram_dq_out` = 0.
  - `_ready` = 0, `_rvalid` = 0, `_rdata` = 0.
- Accept:
  - `_req` sampled high at edge E in IDLE → `_ready` = 1 for exactly the cycle after E.
  - That same cycle is the first RD/WR cycle.
  - The requester may change its fields or drop `_req` starting at the edge after `_ready`.
- Access:
  - RD/WR lasts ACCESS_CYCLES cycles.
  - `_rvalid` is high in the following IDLE cycle.
  - Read latency from the accepting edge to `_rvalid` is ACCESS_CYCLES+1 cycles.
- Throughput: one access per ACCESS_CYCLES+1 cycles. With both ports requesting continuously, grants alternate A, B, A, B.
- A requester still holding `_req` high in the cycle `_ready` is high is not re-accepted, because the state is not IDLE then.
- `rst` during RD/WR: on the next edge the FSM returns to IDLE and outputs take reset values. No `_rvalid` or further `_ready` is produced for the aborted access.
- `rst` overrides any simultaneous request.

## Test plan
- Reset, then A writes 0xBEEF to address 0x00010 with be = 11 at ACCESS_CYCLES = 2:
  - `a_ready` is high 1 cycle later.
  - `we_n` = 0 and `dq_oe` = 1 for exactly 2 cycles, then IDLE strobes.
- A reads 0x00010 with the SRAM model returning 0xBEEF:
  - `a_rvalid` is high 3 cycles after the accepting edge.
  - `a_rdata` = 0xBEEF; `b_rvalid` stays 0.
- A and B request continuously (reads/writes mixed, distinct addresses) for 20 accesses:
  - Grants are A first, then strictly alternating.
  - Every RD/WR burst is separated by at least one IDLE cycle with `dq_oe` = 0.
- Write with be = 10 of 0x12AB, then a read from the same address:
  - `ub_n` = 0 and `lb_n` = 1 during the write.
  - The model shows only the upper byte updated.
- Assert `rst` for 1 cycle in the 2nd cycle of a read:
  - All strobes = 1 on the next cycle.
  - No `rvalid` is produced.
  - A new request is accepted normally afterwards.
- ACCESS_CYCLES = 1, B-only back-to-back reads: `b_ready` pulses every 2 cycles.
